// File: rtl/cpu_pkg.sv
// Shared definitions for the microcoded control unit: sequencer states,
// reserved microaddresses and control-word field widths.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } seq_state_t;

  localparam logic [7:0] HALT_ADDR_DEFAULT = 8'hAA;
  localparam logic [7:0] UADDR_FETCH       = 8'h00;

  // Control-word field widths, most significant field first.
  localparam int CW_ADDR_W    = 8;
  localparam int CW_C_W       = 6;
  localparam int CW_REG_INC_W = 3;
  localparam int CW_B_W       = 3;
  localparam int CW_ALU_W     = 4;
  localparam int CW_M_W       = 3;
  localparam int CW_W = CW_ADDR_W + CW_C_W + CW_REG_INC_W + CW_B_W + CW_ALU_W + CW_M_W;

endpackage

// File: rtl/next_addr_mux.sv
// Combinational next-microaddress select: dispatch beats conditional branch,
// which beats the plain next-address field.
module next_addr_mux
  import cpu_pkg::*;
#(
  parameter int ADDR_W = CW_ADDR_W
) (
  input  logic              jmpc,
  input  logic              z_en,
  input  logic              z_flag,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] opcode,
  output logic [ADDR_W-1:0] next_mpc,
  output logic              next_z_sel
);

  always_comb begin
    next_mpc   = addr;
    next_z_sel = 1'b0;
    if (jmpc) begin
      next_mpc   = opcode;
      next_z_sel = 1'b0;
    end else if (z_en) begin
      next_z_sel = z_flag;
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// Next-microaddress sequencer with start/halt control, memory-stall hold and
// a saturating dispatch counter. All outputs are registered.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start, {z_sel, mpc} parked at the fetch word
//   RUN   | a new microaddress is registered on every edge
//   STALL | memory busy, address held; one extra hold edge on exit
//   HALT  | halt microaddress reached, address frozen until start
module micro_sequencer
  import cpu_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] HALT_ADDR = ADDR_W'(HALT_ADDR_DEFAULT),
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic              jmpc,
  input  logic              z_en,
  input  logic              z_flag,
  input  logic [ADDR_W-1:0] opcode,
  input  logic              stall,
  output logic [ADDR_W-1:0] mpc,
  output logic              z_sel,
  output logic              halted,
  output logic              busy,
  output logic [CNT_W-1:0]  dispatch_cnt
);

  localparam logic [ADDR_W-1:0] FETCH_ADDR = ADDR_W'(UADDR_FETCH);
  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

  seq_state_t        state;
  logic [ADDR_W-1:0] next_mpc;
  logic              next_z_sel;

  next_addr_mux #(.ADDR_W(ADDR_W)) u_next_addr_mux (
    .jmpc       (jmpc),
    .z_en       (z_en),
    .z_flag     (z_flag),
    .addr       (addr),
    .opcode     (opcode),
    .next_mpc   (next_mpc),
    .next_z_sel (next_z_sel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mpc          <= FETCH_ADDR;
      z_sel        <= 1'b0;
      halted       <= 1'b0;
      busy         <= 1'b0;
      dispatch_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          mpc   <= FETCH_ADDR;
          z_sel <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (stall) begin
            state <= STALL;
          end else begin
            mpc   <= next_mpc;
            z_sel <= next_z_sel;
            if (jmpc && (dispatch_cnt != CNT_MAX))
              dispatch_cnt <= dispatch_cnt + 1'b1;
            // Halt is decided on the address being registered, so halted
            // and mpc == HALT_ADDR appear together.
            if (next_mpc == HALT_ADDR) begin
              state  <= HALT;
              halted <= 1'b1;
              busy   <= 1'b0;
            end
          end
        end
        STALL: begin
          if (!stall)
            state <= RUN;
        end
        HALT: begin
          if (start) begin
            state  <= IDLE;
            mpc    <= FETCH_ADDR;
            z_sel  <= 1'b0;
            halted <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer; a second instance with a 2-bit
// dispatch counter shares the stimulus to exercise saturation.
module tb_micro_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, jmpc, z_en, z_flag, stall;
  logic [7:0] addr, opcode;

  logic [7:0]  mpc,  mpc2;
  logic        z_sel, z_sel2, halted, halted2, busy, busy2;
  logic [15:0] dispatch_cnt;
  logic [1:0]  dispatch_cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  micro_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .jmpc(jmpc),
    .z_en(z_en), .z_flag(z_flag), .opcode(opcode), .stall(stall),
    .mpc(mpc), .z_sel(z_sel), .halted(halted), .busy(busy),
    .dispatch_cnt(dispatch_cnt)
  );

  micro_sequencer #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .jmpc(jmpc),
    .z_en(z_en), .z_flag(z_flag), .opcode(opcode), .stall(stall),
    .mpc(mpc2), .z_sel(z_sel2), .halted(halted2), .busy(busy2),
    .dispatch_cnt(dispatch_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_addr(input string tag, input logic [8:0] exp);
    check(tag, {23'd0, z_sel, mpc}, {23'd0, exp});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; jmpc = 1'b0; z_en = 1'b0; z_flag = 1'b0;
    stall = 1'b0; addr = 8'h00; opcode = 8'h00;

    // Reset, then start
    tick(); tick();
    check_addr("rst_addr", 9'h000);
    check("rst_halted", halted, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", dispatch_cnt, 0);

    rst = 1'b0; start = 1'b1;
    tick();
    check_addr("start_addr", 9'h000);
    check("start_busy", busy, 1);
    check("start_halted", halted, 0);
    check("start_cnt", dispatch_cnt, 0);
    start = 1'b0;

    // Dispatch, then plain next-address
    jmpc = 1'b1; opcode = 8'h0D;
    tick();
    check_addr("dispatch_addr", 9'h00D);
    check("dispatch_cnt1", dispatch_cnt, 1);
    jmpc = 1'b0; addr = 8'hC0;
    tick();
    check_addr("plain_addr", 9'h0C0);

    // Conditional branch
    z_en = 1'b1; addr = 8'h50; z_flag = 1'b1;
    tick();
    check_addr("cond_z1", 9'h150);
    z_flag = 1'b0;
    tick();
    check_addr("cond_z0", 9'h050);
    jmpc = 1'b1; z_flag = 1'b1; opcode = 8'h21;
    tick();
    check_addr("jmpc_over_zen", 9'h021);
    check("dispatch_cnt2", dispatch_cnt, 2);
    jmpc = 1'b0; addr = 8'h30;
    tick();
    check_addr("cond_z1_b", 9'h130);
    z_en = 1'b0; addr = 8'h31;
    tick();
    check_addr("zflag_ignored", 9'h031);
    z_flag = 1'b0;

    // Stall hold and one-edge exit hold
    addr = 8'h14;
    tick();
    check_addr("pre_stall", 9'h014);
    stall = 1'b1; addr = 8'h15;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_addr("stall_hold", 9'h014);
      check("stall_busy", busy, 1);
    end
    stall = 1'b0;
    tick();
    check_addr("stall_exit_hold", 9'h014);
    tick();
    check_addr("post_stall", 9'h015);

    // Stall wins over dispatch; dispatch taken after the exit edge
    stall = 1'b1; jmpc = 1'b1; opcode = 8'h40;
    tick();
    check_addr("stall_jmpc", 9'h015);
    check("stall_jmpc_cnt", dispatch_cnt, 2);
    stall = 1'b0;
    tick();
    check_addr("stall_jmpc_exit", 9'h015);
    check("stall_jmpc_exit_cnt", dispatch_cnt, 2);
    tick();
    check_addr("late_dispatch", 9'h040);
    check("late_dispatch_cnt", dispatch_cnt, 3);
    check("sat_cnt_pre", dispatch_cnt2, 3);
    jmpc = 1'b0;

    // Halt
    addr = 8'hAA;
    tick();
    check_addr("halt_addr", 9'h0AA);
    check("halt_flag", halted, 1);
    check("halt_busy", busy, 0);
    addr = 8'h33; jmpc = 1'b1; opcode = 8'h07;
    tick();
    check_addr("halt_frozen", 9'h0AA);
    check("halt_frozen_cnt", dispatch_cnt, 3);
    jmpc = 1'b0; start = 1'b1;
    tick();
    check_addr("halt_to_idle", 9'h000);
    check("halt_release", halted, 0);
    check("idle_busy", busy, 0);
    start = 1'b0; addr = 8'h12;
    tick();
    check_addr("idle_hold", 9'h000);
    check("idle_hold_busy", busy, 0);
    start = 1'b1;
    tick();
    check("rerun_busy", busy, 1);
    check_addr("rerun_addr", 9'h000);
    start = 1'b0;

    // Reset during STALL, then reset beats start
    tick();
    check_addr("rerun_next", 9'h012);
    stall = 1'b1;
    tick();
    check("in_stall_busy", busy, 1);
    rst = 1'b1;
    tick();
    check_addr("rst_stall_addr", 9'h000);
    check("rst_stall_busy", busy, 0);
    check("rst_stall_cnt", dispatch_cnt, 0);
    check("rst_stall_halted", halted, 0);
    rst = 1'b0; stall = 1'b0; addr = 8'h05;
    tick();
    check("post_rst_idle", busy, 0);
    rst = 1'b1; start = 1'b1;
    tick();
    check("rst_beats_start", busy, 0);

    // Counter saturation on the 2-bit instance
    rst = 1'b0;
    tick();
    check("sat_start_busy", busy2, 1);
    start = 1'b0; jmpc = 1'b1; opcode = 8'h01;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("wide_cnt", dispatch_cnt, i);
      check("sat_cnt", dispatch_cnt2, (i > 3) ? 3 : i);
    end

    // Dispatch straight to the halt address
    opcode = 8'hAA;
    tick();
    check_addr("dispatch_halt_addr", 9'h0AA);
    check("dispatch_halt_flag", halted, 1);
    check("dispatch_halt_cnt", dispatch_cnt, 6);
    jmpc = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

- Generates the next microprogram address `{z_sel, mpc}` for the microcoded control unit.
- Each rising edge it consumes the previous control word's sequencing fields (`addr`, `jmpc`, `z_en`), the ALU zero flag and the instruction-register opcode, and registers the next address.
- It also owns start/halt sequencing, memory-stall hold and a dispatch counter.
- The control unit samples `{z_sel, mpc}` on the falling edge, so a new address issued at a rising edge is fetched in the same cycle.

## Interface
- `ADDR_W`, 8: width of `mpc`, `addr`, `opcode`.
- `HALT_ADDR`, 8'hAA: microaddress that marks end of process.
- `CNT_W`, 16: width of the dispatch counter.

Ports:
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: leave IDLE and begin fetching at microaddress 0.
- `addr` input ADDR_W: next-address field of the current control word.
- `jmpc` input 1: dispatch; next address comes from `opcode`.
- `z_en` input 1: conditional branch; next address bit 8 comes from `z_flag`.
- `z_flag` input 1: ALU accumulator-is-zero flag.
- `opcode` input ADDR_W: instruction-register opcode field.
- `stall` input 1: memory busy; hold the current address.
- `mpc` output ADDR_W: microprogram counter, low address bits.
- `z_sel` output 1: control-store address bit 8.
- `halted` output 1: end of process reached.
- `busy` output 1: high in RUN or STALL.
- `dispatch_cnt` output CNT_W: number of dispatches taken; saturates at all-ones.

## Operation
States are IDLE, RUN, STALL and HALT.
- **Reset:** state IDLE. `mpc`=0, `z_sel`=0, `halted`=0, `busy`=0, `dispatch_cnt`=0.
- **IDLE:**
  - `mpc`/`z_sel` held at 0.
  - `start`=1 moves to RUN with `mpc`=0 and `z_sel`=0, so the first fetch is the NOP/dispatch word at address 0.
- **RUN:** the next address is chosen in priority order.
  1. `stall`=1: go to STALL; `mpc`/`z_sel` unchanged.
  2. `jmpc`=1: `mpc`←`opcode`, `z_sel`←0, `dispatch_cnt`+1 (saturating). `z_en` is ignored when `jmpc`=1.
  3. `z_en`=1: `mpc`←`addr`, `z_sel`←`z_flag`.
  4. Otherwise: `mpc`←`addr`, `z_sel`←0.
  - If the newly computed `mpc` equals `HALT_ADDR`, go to HALT in the same edge. The `mpc` value is still registered.
- **STALL:**
  - `mpc`/`z_sel` are held while `stall`=1.
  - On the first edge with `stall`=0, return to RUN. The next address is **not** computed on that edge; it is computed on the following edge.
- **HALT:**
  - `halted`=1; `mpc`/`z_sel` frozen.
  - `start`=1 returns to IDLE with `mpc`=0 and `halted`=0; the block then needs a further `start`=1 to re-run.
- `busy`=1 exactly in RUN and STALL.
- `start` is ignored in RUN and STALL.
- **Width and boundaries:**
  - `mpc` never increments, so it has no wrap-around.
  - `dispatch_cnt` holds at 2^CNT_W−1.
  - `addr`=0 with `jmpc`=0 is legal: it returns to the dispatch word.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Next-address latency: 1 rising edge from the control word fields to `mpc`/`z_sel`.
- The control unit fetches `{z_sel, mpc}` on the falling edge inside the same cycle.
- `z_flag` is sampled only at the edge where `z_en`=1. Later changes do not affect `z_sel` until the next `z_en` edge.
- `rst` overrides all inputs on its edge, including mid-STALL and mid-RUN. The next cycle is IDLE with all reset values.
- `rst` and `start` high together: reset wins.
- `stall` and `jmpc` high together: stall wins. The dispatch is taken on the first RUN edge after the stall, and `jmpc` must still be high then.
- HALT detection uses the registered-next value. `halted` rises on the same edge on which `mpc` becomes `HALT_ADDR`.

## Structure
- Shared package `cpu_pkg` holds:
  - The state enum `seq_state_t` {IDLE, RUN, STALL, HALT}.
  - `HALT_ADDR_DEFAULT` = 8'hAA.
  - Microaddress constant `UADDR_FETCH` = 8'h00.
  - The control-word field widths: Addr 8, C 6, REG_INC 3, B 3, ALU 4, M 3.
- One sub-module, `next_addr_mux`: the combinational priority select of {`addr`, `opcode`} and `z_sel`. The FSM, the registers and the counter stay in `micro_sequencer`.

## Test plan
- **Reset then start:** `rst`=1 for 2 cycles, then `start`=1 → `mpc`=0, `z_sel`=0, `busy`=1, `halted`=0, `dispatch_cnt`=0.
- **Dispatch:** in RUN, `jmpc`=1, `opcode`=8'h0D → next edge `mpc`=8'h0D, `z_sel`=0, `dispatch_cnt`=1. Then `addr`=8'hC0 with `jmpc`=0 → `mpc`=8'hC0.
- **Conditional:** `z_en`=1, `addr`=8'h50.
  - With `z_flag`=1 → `{z_sel,mpc}`=9'h150.
  - Repeat with `z_flag`=0 → 9'h050.
  - `jmpc`=1 together with `z_en`=1 → `z_sel`=0 and `mpc`=`opcode`.
- **Stall:** `mpc`=8'h14, `stall` high for 3 cycles with `addr`=8'h15 → `mpc` stays 8'h14 for those cycles. After `stall` falls there is one hold edge, then `mpc`=8'h15.
- **Halt:** `addr`=8'hAA → `mpc`=8'hAA, `halted`=1, `busy`=0. `mpc` stays frozen under changing `addr`. `start` → IDLE with `mpc`=0 and `halted`=0.
- **Reset mid-op and saturation:**
  - `rst` asserted during STALL → IDLE next cycle with all outputs at reset values.
  - With `CNT_W`=2, 5 dispatches → `dispatch_cnt`=3.
